// File: rtl/rom_ifetch_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_ifetch_if
// Description : ROM request/response and decode-side handshake bundle for
//               the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_ifetch_if;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic        rom_we_o;
    logic [31:0] rom_data_i;
    logic        rom_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        rom_err_o;

    // Fetch unit side
    modport master (
        output rom_addr_o, rom_ce_o, rom_we_o,
        output inst_o, inst_pc_o, inst_valid_o, rom_err_o,
        input  rom_data_i, rom_ready_i, inst_ready_i,
        input  redirect_i, redirect_pc_i
    );

    // ROM / decode / control side
    modport slave (
        input  rom_addr_o, rom_ce_o, rom_we_o,
        input  inst_o, inst_pc_o, inst_valid_o, rom_err_o,
        output rom_data_i, rom_ready_i, inst_ready_i,
        output redirect_i, redirect_pc_i
    );
endinterface
`default_nettype wire

// File: rtl/rom_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : rom_ifetch
// Description : Instruction fetch requester. Issues sequential ROM reads,
//               buffers PC-tagged words in a prefetch FIFO and hands them to
//               decode via valid/ready. Redirect restarts fetch and drops
//               stale words.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_ifetch #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  wire logic    clk,
    input  wire logic    rst,
    rom_ifetch_if.master bus
);
    localparam int unsigned c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]        r_rom_addr;
    logic               r_rom_ce;
    logic [31:0]        r_fetch_pc;
    logic               r_resp_pend;
    logic [31:0]        r_resp_pc;
    logic               r_resp_kill;
    logic               r_err;
    logic [31:0]        r_fifo_inst [FIFO_DEPTH];
    logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_CNT_W:0]   w_occ;
    logic               w_issue;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_redir_pc;

    // Credits count every word that may still land in the FIFO: stored
    // entries, the request on the port and the response in flight.
    assign w_occ      = (c_CNT_W + 1)'(r_count)
                      + (c_CNT_W + 1)'(r_rom_ce)
                      + (c_CNT_W + 1)'(r_resp_pend);
    assign w_issue    = (w_occ < c_DEPTH);
    assign w_valid    = (r_count != '0);
    assign w_push     = r_resp_pend & bus.rom_ready_i & ~r_resp_kill & ~bus.redirect_i;
    assign w_pop      = w_valid & bus.inst_ready_i;
    assign w_redir_pc = {bus.redirect_pc_i[31:2], 2'b00};

    // Control state: request issue, response tracking, FIFO pointers, error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_ce    <= 1'b0;
            r_rom_addr  <= 32'h0;
            r_fetch_pc  <= RESET_PC;
            r_resp_pend <= 1'b0;
            r_resp_pc   <= 32'h0;
            r_resp_kill <= 1'b0;
            r_err       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_resp_pend <= r_rom_ce;
            r_resp_pc   <= r_rom_addr;
            if (r_resp_pend && !bus.rom_ready_i) begin
                r_err <= 1'b1;
            end
            if (bus.redirect_i) begin
                r_rom_ce    <= 1'b1;
                r_rom_addr  <= w_redir_pc;
                r_fetch_pc  <= w_redir_pc + 32'd4;
                // The request on the port now belongs to the old stream.
                r_resp_kill <= r_rom_ce;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
            end else begin
                r_resp_kill <= 1'b0;
                if (w_issue) begin
                    r_rom_ce   <= 1'b1;
                    r_rom_addr <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end else begin
                    r_rom_ce   <= 1'b0;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the count gates the outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= bus.rom_data_i;
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    assign bus.rom_addr_o   = r_rom_addr;
    assign bus.rom_ce_o     = r_rom_ce;
    assign bus.rom_we_o     = 1'b0;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
    assign bus.inst_pc_o    = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
    assign bus.rom_err_o    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_rom_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_ifetch
// Description : Scoreboard bench for rom_ifetch. A ROM responder answers
//               requests one cycle later; the reference expects a gap-free
//               PC stream restarted at each redirect/reset, with stale
//               requests (made before a restart) never delivered.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_ifetch;
    localparam int unsigned c_DEPTH    = 4;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_KEY      = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic rst;
    rom_ifetch_if bus();

    rom_ifetch #(.FIFO_DEPTH(c_DEPTH), .RESET_PC(c_RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    bit   mon_en = 0;
    int   epoch  = 0;
    logic [31:0] model_pc = c_RESET_PC;
    logic exp_err  = 1'b0;
    bit   err_pend = 0;
    bit   push_now = 0;
    bit   withhold_once = 0;
    bit          rq_v  = 0;
    logic [31:0] rq_addr = 32'h0;
    logic [31:0] rq_pc   = 32'h0;
    int          rq_ep   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ROM responder: answers the request seen last cycle; live answers feed the scoreboard.
    always @(posedge clk) begin
        #1;
        push_now = 0;
        if (rq_v) begin
            if (rq_ep == epoch && withhold_once) begin
                bus.rom_ready_i = 1'b0;
                bus.rom_data_i  = $urandom;
                withhold_once   = 0;
                err_pend        = 1;
            end else begin
                bus.rom_ready_i = 1'b1;
                bus.rom_data_i  = rq_addr ^ c_KEY;
                if (rq_ep == epoch) begin
                    exp_q.push_back('{pc: rq_pc, inst: rq_pc ^ c_KEY});
                    push_now = 1;
                end
            end
        end else begin
            bus.rom_ready_i = ($urandom_range(0, 7) == 0);
            bus.rom_data_i  = $urandom;
        end
    end

    // Monitor: compares delivered words, flags and requests against the reference.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("rom_err", 32'(bus.rom_err_o), 32'(exp_err));
            check("rom_we", 32'(bus.rom_we_o), 32'd0);
            check("inst_valid", 32'(bus.inst_valid_o), 32'(exp_q.size() > int'(push_now)));
            if (!rst && !bus.redirect_i) begin
                check("credit", 32'((exp_q.size() + int'(bus.rom_ce_o)) <= int'(c_DEPTH)), 32'd1);
                if (bus.inst_valid_o && bus.inst_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL pop_unexpected: got pc %h want no word", bus.inst_pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_pc", bus.inst_pc_o, e.pc);
                        check("inst", bus.inst_o, e.inst);
                    end
                end
            end
            if (err_pend) exp_err = 1'b1;
            err_pend = 0;
            if (rst) exp_err = 1'b0;
            rq_v = bus.rom_ce_o;
            if (rq_v) begin
                rq_addr = bus.rom_addr_o;
                rq_pc   = model_pc;
                rq_ep   = epoch;
                check("rom_addr", rq_addr, model_pc);
                model_pc = model_pc + 32'd4;
            end
            if (rst) begin
                model_pc = c_RESET_PC;
                exp_q.delete();
                epoch++;
            end else if (bus.redirect_i) begin
                model_pc = {bus.redirect_pc_i[31:2], 2'b00};
                exp_q.delete();
                epoch++;
            end
        end
    end

    task automatic throughput(input string name, input int n);
        int cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.inst_valid_o) cnt++;
        end
        check(name, cnt, n);
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] first_pc);
        @(posedge clk); #1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = tgt;
        @(posedge clk); #1;
        bus.redirect_i    = 1'b0;
        @(negedge clk);
        check("redir_ce_r1", 32'(bus.rom_ce_o), 32'd1);
        check("redir_addr_r1", bus.rom_addr_o, first_pc);
        check("redir_valid_r1", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        check("redir_valid_r2", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        check("redir_valid_r3", 32'(bus.inst_valid_o), 32'd1);
        check("redir_pc_r3", bus.inst_pc_o, first_pc);
        check("redir_inst_r3", bus.inst_o, first_pc ^ c_KEY);
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        bus.inst_ready_i  = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.rom_ready_i   = 1'b0;
        bus.rom_data_i    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.inst_ready_i = 1'b1;
        mon_en = 1;

        // Reset values and first-fetch latency
        @(negedge clk);
        check("rst_ce", 32'(bus.rom_ce_o), 32'd0);
        check("rst_addr", bus.rom_addr_o, 32'h0);
        check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("rst_inst", bus.inst_o, 32'h0);
        check("rst_pc", bus.inst_pc_o, 32'h0);
        @(negedge clk);
        check("first_ce", 32'(bus.rom_ce_o), 32'd1);
        check("first_addr", bus.rom_addr_o, c_RESET_PC);
        check("first_valid_c1", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        check("first_valid_c2", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        check("first_valid_c3", 32'(bus.inst_valid_o), 32'd1);
        check("first_pc", bus.inst_pc_o, c_RESET_PC);
        repeat (4) @(negedge clk);
        throughput("throughput_start", 20);

        // Back-pressure fills the FIFO, then release
        @(posedge clk); #1;
        bus.inst_ready_i = 1'b0;
        repeat (12) @(negedge clk);
        check("stall_ce", 32'(bus.rom_ce_o), 32'd0);
        check("stall_valid", 32'(bus.inst_valid_o), 32'd1);
        check("stall_fill", exp_q.size(), c_DEPTH);
        @(posedge clk); #1;
        bus.inst_ready_i = 1'b1;
        repeat (10) @(negedge clk);
        throughput("throughput_resume", 10);

        // Redirects: in-flight kill, unaligned target, wrap-around
        redirect_to(32'h0000_0100, 32'h0000_0100);
        @(negedge clk);
        check("redir_next_pc", bus.inst_pc_o, 32'h0000_0104);
        repeat (5) @(negedge clk);
        redirect_to(32'h0000_0103, 32'h0000_0100);
        repeat (5) @(negedge clk);
        redirect_to(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_pc", bus.inst_pc_o, 32'h0000_0000);

        // Withheld ROM response sets the sticky error
        @(posedge clk); #1;
        withhold_once = 1;
        waited = 0;
        while (withhold_once && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("withhold_taken", 32'(withhold_once), 32'd0);
        repeat (10) @(negedge clk);
        check("err_sticky", 32'(bus.rom_err_o), 32'd1);

        // Randomized traffic with random redirects and back-pressure
        repeat (400) begin
            @(posedge clk); #1;
            bus.inst_ready_i  = ($urandom_range(0, 3) != 0);
            bus.redirect_i    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc_i = $urandom;
        end
        @(posedge clk); #1;
        bus.redirect_i   = 1'b0;
        bus.inst_ready_i = 1'b1;
        repeat (10) @(negedge clk);

        // Mid-stream reset with a partly full FIFO
        @(posedge clk); #1;
        bus.inst_ready_i = 1'b0;
        waited = 0;
        while (exp_q.size() < 3 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("prefill_reached", 32'(exp_q.size() >= 3), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.inst_ready_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("mid_rst_ce", 32'(bus.rom_ce_o), 32'd0);
        check("mid_rst_err", 32'(bus.rom_err_o), 32'd0);
        @(negedge clk);
        check("mid_rst_addr", bus.rom_addr_o, c_RESET_PC);
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_pc", bus.inst_pc_o, c_RESET_PC);
        throughput("throughput_after_rst", 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
